keypad_password_entry: RTL and testbench

- Password entry block for the 4-digit safe box. Scans a 4x4 active-low matrix keypad, debounces presses, and assembles up to four decimal digits into p0..p3 plus a show/hide flag.
- Its outputs drive the 7-segment password display directly (p0..p3, show_digits).
- It also drives the comparator/lock logic through entry_valid.

---
 rtl/keypad_password_entry.sv | 257 +++++++++++++++++++++++++
 tb/tb_keypad_password_entry.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_password_entry.sv
// keypad_password_entry
//   Scans a 4x4 active-low matrix keypad, debounces key presses over whole
//   scan frames and assembles up to four decimal digits for the safe-box
//   password display and comparator.
//
// Ports
//   clk, rst_n   : 50 MHz clock, asynchronous active-low reset
//   row_in[3:0]  : keypad rows, active-low, asynchronous to clk
//   col_out[3:0] : keypad column drive, active-low one-hot
//   p0..p3[3:0]  : entered digits, p0 newest, p3 oldest
//   digit_cnt    : number of valid digits held (0..4)
//   show_digits  : 1 = show digits, 0 = show dashes
//   key_code     : code of the last accepted key
//   key_strobe   : one-cycle pulse per accepted key press
//   entry_valid  : one-cycle pulse on ENTER (F) with four digits held
//
// Handshake: key_strobe and entry_valid are single-cycle valid pulses with no
// ready/back-pressure; the consumer must sample them on the cycle they are
// high. key_code is stable while key_strobe is high, and p0..p3 hold the
// completed entry while entry_valid is high.
module keypad_password_entry #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] p0,
  output logic [3:0] p1,
  output logic [3:0] p2,
  output logic [3:0] p3,
  output logic [2:0] digit_cnt,
  output logic       show_digits,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output logic       entry_valid
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_N    = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, CAND, PRESSED} state_t;

  // Row synchroniser (idle-high so reset looks like "no key").
  logic [3:0] row_meta, row_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  // Column scan: col_last marks the sampling cycle of the current column.
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic             col_last, frame_end;

  assign col_last  = (div_cnt == DIV_LAST);
  assign frame_end = col_last && (col_idx == 2'd3);
  assign col_out   = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
    end else if (col_last) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Hits in the current column: 0, 1, or 2 meaning "two or more".
  logic [1:0] col_hits, hit_row;
  always_comb begin
    col_hits = 2'd0;
    hit_row  = 2'd0;
    case (~row_sync)
      4'b0000: col_hits = 2'd0;
      4'b0001: begin col_hits = 2'd1; hit_row = 2'd0; end
      4'b0010: begin col_hits = 2'd1; hit_row = 2'd1; end
      4'b0100: begin col_hits = 2'd1; hit_row = 2'd2; end
      4'b1000: begin col_hits = 2'd1; hit_row = 2'd3; end
      default: col_hits = 2'd2;
    endcase
  end

  // Frame accumulator. frame_hits/frame_code include the column being
  // sampled right now, so on frame_end they describe the complete frame.
  logic [1:0] acc_hits, frame_hits;
  logic [3:0] acc_code, frame_code;
  logic [2:0] hit_sum;

  always_comb begin
    hit_sum    = {1'b0, acc_hits} + {1'b0, col_hits};
    frame_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    frame_code = (acc_hits == 2'd0) ? key_map(hit_row, col_idx) : acc_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hits <= 2'd0;
      acc_code <= 4'h0;
    end else if (col_last) begin
      if (col_idx == 2'd3) begin
        acc_hits <= 2'd0;
        acc_code <= 4'h0;
      end else begin
        acc_hits <= frame_hits;
        acc_code <= frame_code;
      end
    end
  end

  // Debounce FSM, advanced only on frame_end.
  state_t     state, state_next;
  logic [3:0] cand, cand_next, stable, stable_next, rel, rel_next;
  logic       accept;

  always_comb begin
    state_next  = state;
    cand_next   = cand;
    stable_next = stable;
    rel_next    = rel;
    accept      = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (frame_hits == 2'd1) begin
            cand_next   = frame_code;
            stable_next = 4'd1;
            rel_next    = 4'd0;
            if (DEB_N == 4'd1) begin
              state_next = PRESSED;
              accept     = 1'b1;
            end else begin
              state_next = CAND;
            end
          end
        end
        CAND: begin
          if (frame_hits == 2'd1 && frame_code == cand) begin
            stable_next = stable + 4'd1;
            if (stable_next == DEB_N) begin
              state_next = PRESSED;
              rel_next   = 4'd0;
              accept     = 1'b1;
            end
          end else if (frame_hits == 2'd1) begin
            cand_next   = frame_code;
            stable_next = 4'd1;
          end else begin
            state_next = IDLE;
          end
        end
        PRESSED: begin
          if (frame_hits == 2'd0) begin
            rel_next = rel + 4'd1;
            if (rel_next == DEB_N) state_next = IDLE;
          end else begin
            rel_next = 4'd0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cand       <= 4'h0;
      stable     <= 4'd0;
      rel        <= 4'd0;
      key_strobe <= 1'b0;
      key_code   <= 4'h0;
    end else begin
      state      <= state_next;
      cand       <= cand_next;
      stable     <= stable_next;
      rel        <= rel_next;
      key_strobe <= accept;
      if (accept) key_code <= cand_next;
    end
  end

  // Entry buffer. Acts on the key_strobe cycle; an ENTER pulse clears the
  // buffer one cycle later so the comparator sees the entry with the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0          <= 4'h0;
      p1          <= 4'h0;
      p2          <= 4'h0;
      p3          <= 4'h0;
      digit_cnt   <= 3'd0;
      show_digits <= 1'b0;
      entry_valid <= 1'b0;
    end else begin
      entry_valid <= 1'b0;
      if (entry_valid) begin
        p0        <= 4'h0;
        p1        <= 4'h0;
        p2        <= 4'h0;
        p3        <= 4'h0;
        digit_cnt <= 3'd0;
      end else if (key_strobe) begin
        if (key_code <= 4'd9) begin
          if (digit_cnt < 3'd4) begin
            p3        <= p2;
            p2        <= p1;
            p1        <= p0;
            p0        <= key_code;
            digit_cnt <= digit_cnt + 3'd1;
          end
        end else begin
          case (key_code)
            4'hA: begin
              p0        <= 4'h0;
              p1        <= 4'h0;
              p2        <= 4'h0;
              p3        <= 4'h0;
              digit_cnt <= 3'd0;
            end
            4'hB: begin
              p0 <= p1;
              p1 <= p2;
              p2 <= p3;
              p3 <= 4'h0;
              if (digit_cnt != 3'd0) digit_cnt <= digit_cnt - 3'd1;
            end
            4'hC: show_digits <= ~show_digits;
            4'hF: if (digit_cnt == 3'd4) entry_valid <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_password_entry.sv
// tb_keypad_password_entry
//   Directed bench for keypad_password_entry with SCAN_DIV=4 and
//   DEBOUNCE_SCANS=2 (one frame = 16 clocks). A keypad model converts the
//   set of held keys into row levels from col_out. Expected key codes and
//   expected ENTER contents are queued when stimulus is issued; a negedge
//   monitor pops and compares on key_strobe / entry_valid.
module tb_keypad_password_entry;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out, p0, p1, p2, p3, key_code;
  logic [2:0] digit_cnt;
  logic       show_digits, key_strobe, entry_valid;

  logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c held
  int          cyc;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          strobe_seen = 0;
  logic        ev_prev = 1'b0;

  logic [3:0]  key_q[$];
  logic [15:0] entry_q[$];

  keypad_password_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .digit_cnt(digit_cnt),
    .show_digits(show_digits), .key_code(key_code),
    .key_strobe(key_strobe), .entry_valid(entry_valid)
  );

  // ---------------- clock / reset-relative cycle counter ----------------
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Keypad model: a held key pulls its row low while its column is driven.
  always_comb begin
    for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_col_out"}, col_out, 4'b1110);
    check({tag, "_digits"}, {p3, p2, p1, p0}, 16'h0000);
    check({tag, "_digit_cnt"}, digit_cnt, 3'd0);
    check({tag, "_show"}, show_digits, 1'b0);
    check({tag, "_key_code"}, key_code, 4'h0);
    check({tag, "_key_strobe"}, key_strobe, 1'b0);
    check({tag, "_entry_valid"}, entry_valid, 1'b0);
  endtask

  function automatic logic [15:0] key_bit(input logic [3:0] code);
    int pos;
    case (code)
      4'h1: pos = 0;   4'h2: pos = 1;   4'h3: pos = 2;   4'hA: pos = 3;
      4'h4: pos = 4;   4'h5: pos = 5;   4'h6: pos = 6;   4'hB: pos = 7;
      4'h7: pos = 8;   4'h8: pos = 9;   4'h9: pos = 10;  4'hC: pos = 11;
      4'hE: pos = 12;  4'h0: pos = 13;  4'hF: pos = 14;  default: pos = 15;
    endcase
    return 16'(1) << pos;
  endfunction

  // Wait for a frame boundary so every press starts at a known scan phase.
  task automatic align_frame();
    int guard = 0;
    while ((cyc % 16) != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("frame_align_timeout", cyc % 16, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic hold_mask(input logic [15:0] m, input int hold_f, input int rel_f);
    align_frame();
    keys = m;
    repeat (hold_f * 16) @(negedge clk);
    keys = '0;
    repeat (rel_f * 16) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] code);
    key_q.push_back(code);
    hold_mask(key_bit(code), 6, 3);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (ev_prev) begin
        check("digits_after_enter", {p3, p2, p1, p0}, 16'h0000);
        check("cnt_after_enter", digit_cnt, 3'd0);
      end
      if (key_strobe) begin
        strobe_seen++;
        check("strobe_entry_overlap", entry_valid, 1'b0);
        if (key_q.size() == 0) check("unexpected_strobe", key_strobe, 1'b0);
        else                   check("key_code", key_code, key_q.pop_front());
      end
      if (entry_valid) begin
        if (entry_q.size() == 0) check("unexpected_entry", entry_valid, 1'b0);
        else                     check("entry_digits", {p3, p2, p1, p0}, entry_q.pop_front());
      end
      ev_prev = entry_valid;
    end else begin
      ev_prev = 1'b0;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int         s;
    logic [3:0] exp_col;

    repeat (3) @(negedge clk);
    check_reset_values("rst");

    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << (((i + 1) / 4) % 4));
      check("col_scan", col_out, exp_col);
    end
    repeat (64) @(negedge clk);
    check("idle_digits", {p3, p2, p1, p0}, 16'h0000);
    check("idle_cnt", digit_cnt, 3'd0);
    check("idle_show", show_digits, 1'b0);

    // Four digits in.
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    check("four_digits", {p3, p2, p1, p0}, 16'h1234);
    check("four_cnt", digit_cnt, 3'd4);

    // Fifth digit ignored.
    press(4'h5);
    check("full_ignore_digits", {p3, p2, p1, p0}, 16'h1234);
    check("full_ignore_cnt", digit_cnt, 3'd4);

    // Backspace.
    press(4'hB);
    check("bksp_digits", {p3, p2, p1, p0}, 16'h0123);
    check("bksp_cnt", digit_cnt, 3'd3);

    // Show toggle.
    press(4'hC);
    check("show_on", show_digits, 1'b1);
    check("show_digits_kept", {p3, p2, p1, p0}, 16'h0123);

    // Clear.
    press(4'hA);
    check("clear_digits", {p3, p2, p1, p0}, 16'h0000);
    check("clear_cnt", digit_cnt, 3'd0);

    // Full entry and ENTER.
    press(4'h9); press(4'h8); press(4'h7); press(4'h6);
    check("entry_digits_pre", {p3, p2, p1, p0}, 16'h9876);
    entry_q.push_back(16'h9876);
    press(4'hF);
    check("enter_consumed", entry_q.size(), 0);
    check("enter_cnt", digit_cnt, 3'd0);
    check("enter_digits", {p3, p2, p1, p0}, 16'h0000);

    // ENTER with nothing held: strobe only.
    press(4'hF);
    check("empty_enter_cnt", digit_cnt, 3'd0);

    // Key 7 bouncing every frame.
    s = strobe_seen;
    align_frame();
    for (int i = 0; i < 6; i++) begin
      keys = key_bit(4'h7);
      repeat (16) @(negedge clk);
      keys = '0;
      repeat (16) @(negedge clk);
    end
    repeat (48) @(negedge clk);
    check("bounce_no_strobe", strobe_seen, s);

    // Keys 1 and 5 together.
    s = strobe_seen;
    hold_mask(key_bit(4'h1) | key_bit(4'h5), 6, 3);
    check("multi_no_strobe", strobe_seen, s);
    check("multi_cnt", digit_cnt, 3'd0);

    // Long hold with a one-frame release glitch.
    s = strobe_seen;
    key_q.push_back(4'h8);
    align_frame();
    keys = key_bit(4'h8);
    repeat (160) @(negedge clk);
    keys = '0;
    repeat (16) @(negedge clk);
    keys = key_bit(4'h8);
    repeat (160) @(negedge clk);
    keys = '0;
    repeat (48) @(negedge clk);
    check("glitch_single_strobe", strobe_seen, s + 1);
    check("glitch_digits", {p3, p2, p1, p0}, 16'h0008);

    press(4'h2);
    check("two_digits", {p3, p2, p1, p0}, 16'h0082);
    check("two_cnt", digit_cnt, 3'd2);

    // Reset while key 5 is a debounce candidate.
    align_frame();
    keys = key_bit(4'h5);
    repeat (20) @(negedge clk);
    s = strobe_seen;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    key_q.push_back(4'h5);
    repeat (30) @(negedge clk);
    check("post_rst_no_early_strobe", strobe_seen, s);
    repeat (10) @(negedge clk);
    check("post_rst_strobe", strobe_seen, s + 1);
    keys = '0;
    repeat (48) @(negedge clk);
    check("post_rst_digits", {p3, p2, p1, p0}, 16'h0005);
    check("post_rst_cnt", digit_cnt, 3'd1);

    check("key_q_drained", key_q.size(), 0);
    check("entry_q_drained", entry_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
